mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle main controller for the MIPS datapath. It is a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several cycles, and stalls on a memory ready handshake. It drives every datapath select and enable, including `ExtOp` to the immediate extender (00 zero, 01 sign). It also keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 32, width of the retired-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE until the instruction completes.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `PCWrite`, `PCWriteCond`, `BranchNe`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  datapath enables/selects.
- `ALUSrcB`  out  2  00 reg B, 01 const 4, 10 imm32, 11 imm32<<2.
- `ALUOp`  out  2  00 add, 01 sub, 10 funct, 11 immediate op.
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- `ExtOp`  out  2  to extender; 00 ZERO, 01 SIGN.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `illegal_op`  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- `instr_count`  out  CNT_W  retired instructions.

## Operation
- Any output not listed for a state is 0; `ExtOp` defaults to ZERO.
- FETCH(0):
  - Outputs: MemRead=1, ALUSrcB=01.
  - When `mem_ready` is high: IRWrite=1, PCWrite=1, and the next state is DECODE. Otherwise the FSM stays in FETCH.
- DECODE(1):
  - Outputs: ALUSrcB=11, ExtOp=SIGN.
  - Branch on opcode: 000000 → RTYPE_EX; 100011/101011 (lw/sw) → MEMADR; 000100/000101 (beq/bne) → BRANCH; 001000/001100/001101 (addi/andi/ori) → IMM_EX; 000010 (j) → JUMP.
  - Any other opcode → FETCH, with `illegal_op`=1.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ExtOp=SIGN. Next is MEMRD for lw, MEMWR for sw.
- MEMRD(3): MemRead=1, IorD=1. Advances to MEMWB on `mem_ready`.
- MEMWB(4): RegWrite=1, MemtoReg=1. Retires, next FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Retires and returns to FETCH on `mem_ready`.
- RTYPE_EX(6): ALUSrcA=1, ALUOp=10. Next RTYPE_WB.
- RTYPE_WB(7): RegWrite=1, RegDst=1. Retires.
- BRANCH(8): ALUSrcA=1, ALUOp=01, PCSource=01, PCWriteCond=1, BranchNe=(opcode==000101). Retires.
- IMM_EX(9): ALUSrcA=1, ALUSrcB=10, ALUOp=11. ExtOp=SIGN for addi, ZERO for andi/ori. Next IMM_WB.
- IMM_WB(10): RegWrite=1, with `ExtOp` held as in IMM_EX. Retires.
- JUMP(11): PCWrite=1, PCSource=10. Retires.
- Encodings 12–15 are unreachable; if entered, the FSM goes to FETCH with no outputs asserted.
- Retire: `instr_done`=1 on the cycle the FSM leaves a final state for FETCH; `instr_count` increments at that edge.
- Counter wraps modulo 2^CNT_W.
- An illegal opcode does not count as retired.

## Timing
- State, `instr_count`: registered. All other outputs: combinational from state, plus `opcode`/`mem_ready`.
- Reset:
  - While `rst`=1, all write/read enables (PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead) and both pulses are forced to 0.
  - Next edge: state=FETCH, `instr_count`=0.
  - Reset wins over every transition, including mid-MEMWR or mid-stall; no partial commit follows.
- Cycles per instruction with `mem_ready` held high: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi/andi/ori 4.
- Each low cycle of `mem_ready` in FETCH/MEMRD/MEMWR adds exactly one cycle. All outputs are held steady during the stall.
- `mem_ready` is ignored in every other state.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants;
  - ExtOp ZERO/SIGN constants, the same values the extender uses;
  - ALUOp, ALUSrcB and PCSource encodings;
  - the 4-bit state enum.
- `mc_ctrl` is a single module: state register, next-state logic, output decode, counter.
- No sub-module is needed. An optional output-decode function lives in the package.

## Test plan
- Reset, then lw with `mem_ready`=1 throughout → states 0,1,2,3,4 with MEMWB RegWrite=1, MemtoReg=1; `instr_count`=1 after 5 cycles.
- lw with `mem_ready` low 2 cycles in MEMRD → 7 cycles total; MemRead=1, IorD=1 held for all 3 MEMRD cycles.
- ori (001101) → ExtOp=00 in IMM_EX; then addi (001000) → ExtOp=01; both 4 cycles with RegWrite=1 only in IMM_WB.
- bne (000101) → BRANCH with PCWriteCond=1, BranchNe=1, PCSource=01; beq gives BranchNe=0; 3 cycles each.
- opcode 111111 → `illegal_op` pulse in DECODE, back to FETCH, `instr_count` unchanged.
- `rst` asserted during MEMWR stall → MemWrite=0 that cycle, FETCH and count 0 next edge; then j retires in 3 cycles with PCSource=10.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS multicycle definitions: opcodes, datapath select encodings,
// controller state enum and the per-state control decode used by mc_ctrl.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Must match the immediate extender's select encoding.
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPE_EX = 4'd6,
    S_RTYPE_WB = 4'd7,
    S_BRANCH   = 4'd8,
    S_IMM_EX   = 4'd9,
    S_IMM_WB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       branchne;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic [1:0] extop;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_supported = 1'b1;
      default:                        op_supported = 1'b0;
    endcase
  endfunction

  function automatic ctrl_t ctrl_decode(input state_t s, input logic [5:0] op,
                                        input logic rdy);
    ctrl_t c;
    c          = '0;
    c.alusrcb  = SRCB_REG;
    c.aluop    = ALUOP_ADD;
    c.pcsource = PCSRC_ALU;
    c.extop    = EXT_ZERO;
    case (s)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_FOUR;
        c.irwrite = rdy;
        c.pcwrite = rdy;
      end
      S_DECODE: begin
        c.alusrcb    = SRCB_IMMSH;
        c.extop      = EXT_SIGN;
        c.illegal_op = ~op_supported(op);
      end
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.extop   = EXT_SIGN;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.instr_done = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite   = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = rdy;
      end
      S_RTYPE_EX: begin
        c.alusrca = 1'b1;
        c.aluop   = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        c.regwrite   = 1'b1;
        c.regdst     = 1'b1;
        c.instr_done = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca     = 1'b1;
        c.aluop       = ALUOP_SUB;
        c.pcsource    = PCSRC_ALUOUT;
        c.pcwritecond = 1'b1;
        c.branchne    = (op == OP_BNE);
        c.instr_done  = 1'b1;
      end
      S_IMM_EX: begin
        c.alusrca = 1'b1;
        c.alusrcb = SRCB_IMM;
        c.aluop   = ALUOP_IMM;
        c.extop   = (op == OP_ADDI) ? EXT_SIGN : EXT_ZERO;
      end
      S_IMM_WB: begin
        c.regwrite   = 1'b1;
        c.extop      = (op == OP_ADDI) ? EXT_SIGN : EXT_ZERO;
        c.instr_done = 1'b1;
      end
      S_JUMP: begin
        c.pcwrite    = 1'b1;
        c.pcsource   = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH: n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:                n = S_RTYPE_EX;
          OP_LW, OP_SW:            n = S_MEMADR;
          OP_BEQ, OP_BNE:          n = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: n = S_IMM_EX;
          OP_J:                    n = S_JUMP;
          default:                 n = S_FETCH;
        endcase
      end
      S_MEMADR:   n = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    n = rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:    n = rdy ? S_FETCH : S_MEMWR;
      S_RTYPE_EX: n = S_RTYPE_WB;
      S_IMM_EX:   n = S_IMM_WB;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main controller: state register, next-state/output decode
// from mips_pkg, and a retired-instruction counter.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [1:0]       ExtOp,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, state_nx;
  ctrl_t  c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= state_nx;
      if (c.instr_done) instr_count <= instr_count + 1'b1;
    end
  end

  // Reset masks every enable and pulse so nothing commits while held.
  always_comb begin
    c        = ctrl_decode(state, opcode, mem_ready);
    state_nx = next_state(state, opcode, mem_ready);
    if (rst) begin
      c.pcwrite     = 1'b0;
      c.pcwritecond = 1'b0;
      c.irwrite     = 1'b0;
      c.regwrite    = 1'b0;
      c.memwrite    = 1'b0;
      c.memread     = 1'b0;
      c.instr_done  = 1'b0;
      c.illegal_op  = 1'b0;
    end
  end

  assign PCWrite     = c.pcwrite;
  assign PCWriteCond = c.pcwritecond;
  assign BranchNe    = c.branchne;
  assign IorD        = c.iord;
  assign MemRead     = c.memread;
  assign MemWrite    = c.memwrite;
  assign IRWrite     = c.irwrite;
  assign MemtoReg    = c.memtoreg;
  assign RegDst      = c.regdst;
  assign RegWrite    = c.regwrite;
  assign ALUSrcA     = c.alusrca;
  assign ALUSrcB     = c.alusrcb;
  assign ALUOp       = c.aluop;
  assign PCSource    = c.pcsource;
  assign ExtOp       = c.extop;
  assign instr_done  = c.instr_done;
  assign illegal_op  = c.illegal_op;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected control sequences
// built from the instruction class, with random memory stalls.
module tb_mc_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, ALUOp, PCSource, ExtOp;
  logic          instr_done, illegal_op;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int failures = 0;
  int unsigned retired = 0;

  typedef struct packed {
    logic       pcwrite, pcwritecond, branchne, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource, extop;
    logic       done, illegal;
  } exp_t;

  typedef struct {
    logic rdy;
    exp_t e;
  } step_t;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .ExtOp(ExtOp), .instr_done(instr_done), .illegal_op(illegal_op),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t sample();
    exp_t o;
    o = '{PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
          MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp,
          instr_done, illegal_op};
    return o;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expected per-cycle sequence for one instruction, by instruction class.
  function automatic void build(input logic [5:0] op, input int unsigned fs,
                                input int unsigned ms, output step_t q[$]);
    exp_t e;
    bit   ok;
    q.delete();
    ok = (op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h02});
    for (int i = 0; i < int'(fs); i++) begin
      e = '0; e.memread = 1; e.alusrcb = 2'b01;
      q.push_back('{1'b0, e});
    end
    e = '0; e.memread = 1; e.alusrcb = 2'b01; e.irwrite = 1; e.pcwrite = 1;
    q.push_back('{1'b1, e});
    e = '0; e.alusrcb = 2'b11; e.extop = 2'b01; e.illegal = !ok;
    q.push_back('{rbit(), e});
    if (!ok) return;
    case (op)
      6'h23, 6'h2b: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10; e.extop = 2'b01;
        q.push_back('{rbit(), e});
        e = '0; e.iord = 1;
        if (op == 6'h23) e.memread = 1; else e.memwrite = 1;
        for (int i = 0; i < int'(ms); i++) q.push_back('{1'b0, e});
        if (op == 6'h2b) e.done = 1;
        q.push_back('{1'b1, e});
        if (op == 6'h23) begin
          e = '0; e.regwrite = 1; e.memtoreg = 1; e.done = 1;
          q.push_back('{rbit(), e});
        end
      end
      6'h00: begin
        e = '0; e.alusrca = 1; e.aluop = 2'b10;
        q.push_back('{rbit(), e});
        e = '0; e.regwrite = 1; e.regdst = 1; e.done = 1;
        q.push_back('{rbit(), e});
      end
      6'h04, 6'h05: begin
        e = '0; e.alusrca = 1; e.aluop = 2'b01; e.pcsource = 2'b01;
        e.pcwritecond = 1; e.branchne = (op == 6'h05); e.done = 1;
        q.push_back('{rbit(), e});
      end
      6'h02: begin
        e = '0; e.pcwrite = 1; e.pcsource = 2'b10; e.done = 1;
        q.push_back('{rbit(), e});
      end
      default: begin
        e = '0; e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 2'b11;
        e.extop = (op == 6'h08) ? 2'b01 : 2'b00;
        q.push_back('{rbit(), e});
        e = '0; e.regwrite = 1; e.extop = (op == 6'h08) ? 2'b01 : 2'b00; e.done = 1;
        q.push_back('{rbit(), e});
      end
    endcase
    retired++;
  endfunction

  // Assumes entry at posedge+1 with the FSM in FETCH.
  task automatic run_instr(input logic [5:0] op, input int unsigned fs,
                           input int unsigned ms, input int unsigned want_len,
                           input string name);
    step_t q[$];
    exp_t  o;
    build(op, fs, ms, q);
    opcode = op;
    checks++;
    if (want_len != 0 && q.size() != want_len) begin
      failures++;
      $display("FAIL %s_len: got %0d cycles, expected %0d", name, q.size(), want_len);
    end
    foreach (q[i]) begin
      mem_ready = q[i].rdy;
      #1;
      o = sample();
      checks++;
      if (o !== q[i].e) begin
        failures++;
        $display("FAIL %s_cyc%0d: got %h expected %h", name, i, o, q[i].e);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (instr_count !== CW'(retired)) begin
      failures++;
      $display("FAIL %s_count: got %0d expected %0d", name, instr_count, CW'(retired));
    end
  endtask

  task automatic test_reset();
    rst = 1; mem_ready = 1; opcode = 6'h23;
    @(posedge clk); #1;
    checks++;
    if ({PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead, instr_done, illegal_op} !== 8'h00) begin
      failures++;
      $display("FAIL reset_enables: got %b expected 00000000",
               {PCWrite, PCWriteCond, IRWrite, RegWrite, MemWrite, MemRead, instr_done, illegal_op});
    end
    @(posedge clk); #1;
    checks++;
    if (instr_count !== '0) begin
      failures++;
      $display("FAIL reset_count: got %0d expected 0", instr_count);
    end
    rst = 0;
    retired = 0;
  endtask

  task automatic test_lw();
    run_instr(6'h23, 0, 0, 5, "lw");
    run_instr(6'h23, 0, 2, 7, "lw_stall");
    run_instr(6'h2b, 0, 0, 4, "sw");
    run_instr(6'h00, 0, 0, 4, "rtype");
  endtask

  task automatic test_imm();
    run_instr(6'h0d, 0, 0, 4, "ori");
    run_instr(6'h08, 0, 0, 4, "addi");
    run_instr(6'h0c, 1, 0, 5, "andi_fstall");
  endtask

  task automatic test_branch();
    run_instr(6'h05, 0, 0, 3, "bne");
    run_instr(6'h04, 0, 0, 3, "beq");
  endtask

  task automatic test_illegal();
    run_instr(6'h3f, 0, 0, 2, "illegal");
    run_instr(6'h02, 0, 0, 3, "j_after_illegal");
  endtask

  task automatic test_reset_mid_memwr();
    opcode = 6'h2b;
    mem_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 0;
    @(posedge clk); #1;
    rst = 1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || instr_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_memwr: got MemWrite=%b done=%b expected 0 0", MemWrite, instr_done);
    end
    @(posedge clk); #1;
    rst = 0;
    retired = 0;
    #1;
    checks++;
    if (instr_count !== '0 || MemRead !== 1'b1 || ALUSrcB !== 2'b01 || IRWrite !== 1'b0 || MemWrite !== 1'b0) begin
      failures++;
      $display("FAIL rst_to_fetch: got cnt=%0d MemRead=%b ALUSrcB=%b IRWrite=%b MemWrite=%b expected 0 1 01 0 0",
               instr_count, MemRead, ALUSrcB, IRWrite, MemWrite);
    end
    @(posedge clk); #1;
    run_instr(6'h02, 0, 0, 3, "j_after_rst");
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h02, 6'h3f};
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), 0, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_imm();
    test_branch();
    test_illegal();
    test_reset_mid_memwr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
